// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uart_pkg
// Purpose  : Opcodes, reply codes and FSM state type for the UART responder.
// Revision : 1.0 - initial release
// ============================================================================
package uart_pkg;

    localparam logic [7:0] OP_WR = 8'h57;
    localparam logic [7:0] OP_RD = 8'h52;
    localparam logic [7:0] ACK   = 8'h06;
    localparam logic [7:0] NAK   = 8'h15;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        GET_A = 3'd1,
        GET_D = 3'd2,
        EXEC  = 3'd3,
        SEND  = 3'd4
    } resp_state_t;

endpackage
`default_nettype wire

// File: rtl/uart_cmd_responder_if.sv
`default_nettype none
// ============================================================================
// Module   : uart_cmd_responder_if
// Purpose  : FIFO-side handshake between the UART core and the command responder.
// Revision : 1.0 - initial release
// ============================================================================
interface uart_cmd_responder_if #(
    parameter int W_DATA = 8
);
    logic [W_DATA-1:0] rd_data;
    logic              Rx_empty;
    logic              parity_error;
    logic              framing_error;
    logic              Tx_full;
    logic              rd_uart;
    logic              wr_uart;
    logic [W_DATA-1:0] wr_data;

    // master = responder (host side), slave = UART core
    modport master (
        input  rd_data, Rx_empty, parity_error, framing_error, Tx_full,
        output rd_uart, wr_uart, wr_data
    );

    modport slave (
        output rd_data, Rx_empty, parity_error, framing_error, Tx_full,
        input  rd_uart, wr_uart, wr_data
    );
endinterface
`default_nettype wire

// File: rtl/uart_regfile.sv
`default_nettype none
// ============================================================================
// Module   : uart_regfile
// Purpose  : N_REGS x W_DATA register file, sync write, comb read, flat bus out.
// Revision : 1.0 - initial release
// ============================================================================
module uart_regfile #(
    parameter int W_DATA = 8,
    parameter int N_REGS = 8
) (
    input  wire logic                     clk,
    input  wire logic                     rst_n,
    input  wire logic                     i_we,
    input  wire logic [W_DATA-1:0]        i_addr,
    input  wire logic [W_DATA-1:0]        i_wdata,
    output logic      [W_DATA-1:0]        o_rdata,
    output logic      [N_REGS*W_DATA-1:0] o_reg_bus
);

    logic [W_DATA-1:0] r_regs [N_REGS];

    // Full-width address match: out-of-range addresses hit no register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < N_REGS; i++) begin
                r_regs[i] <= '0;
            end
        end else if (i_we) begin
            for (int i = 0; i < N_REGS; i++) begin
                if (32'(i_addr) == 32'(i)) begin
                    r_regs[i] <= i_wdata;
                end
            end
        end
    end

    always_comb begin
        o_rdata = '0;
        for (int i = 0; i < N_REGS; i++) begin
            if (32'(i_addr) == 32'(i)) begin
                o_rdata = r_regs[i];
            end
        end
    end

    for (genvar g = 0; g < N_REGS; g++) begin : g_bus
        assign o_reg_bus[g*W_DATA +: W_DATA] = r_regs[g];
    end

endmodule
`default_nettype wire

// File: rtl/uart_cmd_responder.sv
`default_nettype none
// ============================================================================
// Module   : uart_cmd_responder
// Purpose  : Executes WRITE/READ command frames from the UART Rx FIFO on a
//            register file and pushes one reply byte per frame to the Tx FIFO.
// Revision : 1.0 - initial release
// ============================================================================
module uart_cmd_responder
    import uart_pkg::*;
#(
    parameter int W_DATA  = 8,
    parameter int N_REGS  = 8,
    parameter int TIMEOUT = 50000
) (
    input  wire logic                     clk,
    input  wire logic                     rst_n,
    uart_cmd_responder_if.master          bus,
    output logic      [N_REGS*W_DATA-1:0] reg_bus,
    output logic                          busy,
    output logic                          cmd_err
);

    localparam int c_TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    resp_state_t       r_state;
    logic [W_DATA-1:0] r_op;
    logic [W_DATA-1:0] r_addr;
    logic [W_DATA-1:0] r_data;
    logic [W_DATA-1:0] r_reply;
    logic              r_nak;
    logic              r_line_err;
    logic [c_TW-1:0]   r_tcnt;

    logic              w_pop_state;
    logic              w_wait_state;
    logic              w_pop;
    logic              w_push;
    logic              w_timeout;
    logic              w_addr_ok;
    logic              w_exec_ok;
    logic              w_is_wr;
    logic              w_is_op;
    logic              w_we;
    logic [W_DATA-1:0] w_rdata;

    assign w_pop_state  = (r_state == IDLE) || (r_state == GET_A) || (r_state == GET_D);
    assign w_wait_state = (r_state == GET_A) || (r_state == GET_D);

    // Strobes are gated by rst_n so nothing is popped or pushed while in reset.
    assign w_pop     = rst_n && w_pop_state && !bus.Rx_empty;
    assign w_push    = rst_n && (r_state == SEND) && !bus.Tx_full;
    assign w_timeout = rst_n && w_wait_state && !w_pop && (r_tcnt == c_TW'(TIMEOUT - 1));

    assign w_addr_ok = 32'(r_addr) < 32'(N_REGS);
    assign w_exec_ok = w_addr_ok && !r_line_err;
    assign w_is_wr   = (r_op == W_DATA'(OP_WR));
    assign w_is_op   = (bus.rd_data == W_DATA'(OP_WR)) || (bus.rd_data == W_DATA'(OP_RD));
    assign w_we      = (r_state == EXEC) && w_exec_ok && w_is_wr;

    uart_regfile #(
        .W_DATA (W_DATA),
        .N_REGS (N_REGS)
    ) u_regfile (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_we      (w_we),
        .i_addr    (r_addr),
        .i_wdata   (r_data),
        .o_rdata   (w_rdata),
        .o_reg_bus (reg_bus)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_op       <= '0;
            r_addr     <= '0;
            r_data     <= '0;
            r_reply    <= '0;
            r_nak      <= 1'b0;
            r_line_err <= 1'b0;
            r_tcnt     <= '0;
        end else begin
            if ((r_state != IDLE) && (bus.parity_error || bus.framing_error)) begin
                r_line_err <= 1'b1;
            end

            if (w_pop) begin
                r_tcnt <= '0;
            end else if (w_wait_state) begin
                r_tcnt <= r_tcnt + c_TW'(1);
            end

            case (r_state)
                IDLE: begin
                    if (w_pop) begin
                        r_op       <= bus.rd_data;
                        r_line_err <= 1'b0;
                        if (w_is_op) begin
                            r_state <= GET_A;
                        end else begin
                            r_reply <= W_DATA'(NAK);
                            r_nak   <= 1'b1;
                            r_state <= SEND;
                        end
                    end
                end

                GET_A: begin
                    if (w_pop) begin
                        r_addr  <= bus.rd_data;
                        r_state <= w_is_wr ? GET_D : EXEC;
                    end else if (w_timeout) begin
                        r_state <= IDLE;
                    end
                end

                GET_D: begin
                    if (w_pop) begin
                        r_data  <= bus.rd_data;
                        r_state <= EXEC;
                    end else if (w_timeout) begin
                        r_state <= IDLE;
                    end
                end

                EXEC: begin
                    if (!w_exec_ok) begin
                        r_reply <= W_DATA'(NAK);
                        r_nak   <= 1'b1;
                    end else if (w_is_wr) begin
                        r_reply <= W_DATA'(ACK);
                        r_nak   <= 1'b0;
                    end else begin
                        r_reply <= w_rdata;
                        r_nak   <= 1'b0;
                    end
                    r_state <= SEND;
                end

                SEND: begin
                    if (w_push) begin
                        r_state <= IDLE;
                    end
                end

                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.rd_uart = w_pop;
    assign bus.wr_uart = w_push;
    assign bus.wr_data = r_reply;
    assign busy        = rst_n && (r_state != IDLE);
    // r_nak distinguishes a NAK reply from a READ that happens to return 0x15.
    assign cmd_err     = (w_push && r_nak) || w_timeout;

endmodule
`default_nettype wire

// File: tb/tb_uart_cmd_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_cmd_responder
// Purpose  : Scoreboard bench for uart_cmd_responder with a modelled Rx FIFO.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_cmd_responder;

    localparam int W_DATA  = 8;
    localparam int N_REGS  = 8;
    localparam int TIMEOUT = 40;

    logic                     clk;
    logic                     rst_n;
    logic [N_REGS*W_DATA-1:0] reg_bus;
    logic                     busy;
    logic                     cmd_err;

    uart_cmd_responder_if #(.W_DATA(W_DATA)) bus ();

    uart_cmd_responder #(
        .W_DATA  (W_DATA),
        .N_REGS  (N_REGS),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .bus     (bus),
        .reg_bus (reg_bus),
        .busy    (busy),
        .cmd_err (cmd_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        bit         tmo;
        bit         nak;
        logic [7:0] data;
    } exp_t;

    exp_t       exp_q [$];
    logic [7:0] push_q [$];
    logic [7:0] rx_q [$];
    logic [7:0] mregs [N_REGS];
    int         n_cmp = 0;
    int         n_err = 0;
    int         n_pops = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] pack_regs();
        logic [63:0] r;
        r = '0;
        for (int i = 0; i < N_REGS; i++) r[i*8 +: 8] = mregs[i];
        return r;
    endfunction

    task automatic push(input logic [7:0] b);
        push_q.push_back(b);
    endtask

    task automatic expect_reply(input logic [7:0] d, input bit nak);
        exp_t e;
        e.tmo = 1'b0; e.nak = nak; e.data = d;
        exp_q.push_back(e);
    endtask

    task automatic expect_tmo();
        exp_t e;
        e.tmo = 1'b1; e.nak = 1'b0; e.data = 8'h00;
        exp_q.push_back(e);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input string name, input int budget);
        int k;
        k = 0;
        forever begin
            @(negedge clk);
            k++;
            if ((!busy && rx_q.size() == 0 && push_q.size() == 0) || k >= budget) break;
        end
        check({name, "_idle"}, {busy, rx_q.size() != 0}, 0);
        tick(1);
    endtask

    task automatic wait_push(input string name, input int budget);
        int k;
        k = 0;
        forever begin
            @(negedge clk);
            k++;
            if (bus.wr_uart || k >= budget) break;
        end
        check({name, "_push_seen"}, bus.wr_uart, 1);
    endtask

    // Rx FIFO model: show-ahead head, pops on rd_uart at the clock edge.
    initial begin
        logic p;
        bus.Rx_empty = 1'b1;
        bus.rd_data  = '0;
        forever begin
            @(posedge clk);
            p = bus.rd_uart;
            #2;
            if (p && rx_q.size() > 0) begin
                void'(rx_q.pop_front());
                n_pops++;
            end
            while (push_q.size() > 0) rx_q.push_back(push_q.pop_front());
            bus.Rx_empty = (rx_q.size() == 0);
            bus.rd_data  = (rx_q.size() > 0) ? rx_q[0] : 8'h00;
        end
    end

    // Monitor: every reply push or cmd_err pulse consumes one scoreboard entry.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            check("rd_while_empty", bus.rd_uart & bus.Rx_empty, 0);
            if (bus.wr_uart || cmd_err) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_output", {bus.wr_uart, cmd_err, bus.wr_data}, 0);
                end else begin
                    e = exp_q.pop_front();
                    if (e.tmo) begin
                        check("tmo_wr_uart", bus.wr_uart, 0);
                        check("tmo_cmd_err", cmd_err, 1);
                    end else begin
                        check("reply_wr_uart", bus.wr_uart, 1);
                        check("reply_data", bus.wr_data, e.data);
                        check("reply_cmd_err", cmd_err, e.nak);
                    end
                end
            end
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int p0;
        int k;
        int seen;
        int cnt;
        for (int i = 0; i < N_REGS; i++) mregs[i] = 8'h00;
        rst_n             = 1'b0;
        bus.Tx_full       = 1'b0;
        bus.parity_error  = 1'b0;
        bus.framing_error = 1'b0;

        tick(3);
        @(negedge clk);
        check("reset_outs", {bus.rd_uart, bus.wr_uart, bus.wr_data, busy, cmd_err}, 0);
        check("reset_regs", reg_bus, 0);
        tick(1);
        rst_n = 1'b1;
        tick(2);

        // 1: write reg 3
        p0 = n_pops;
        push(8'h57); push(8'h03); push(8'hA5);
        expect_reply(8'h06, 1'b0);
        mregs[3] = 8'hA5;
        wait_push("t1", 30);
        check("t1_reg_at_push", reg_bus, pack_regs());
        wait_idle("t1", 30);
        check("t1_pops", n_pops - p0, 3);

        // 2: read reg 3
        push(8'h52); push(8'h03);
        expect_reply(8'hA5, 1'b0);
        wait_idle("t2", 30);
        check("t2_regs", reg_bus, pack_regs());

        // 3: out-of-range write, then bad opcode
        push(8'h57); push(8'h09); push(8'h11);
        expect_reply(8'h15, 1'b1);
        wait_idle("t3a", 30);
        check("t3_regs", reg_bus, pack_regs());
        push(8'h33);
        expect_reply(8'h15, 1'b1);
        wait_idle("t3b", 30);

        // address boundaries: last valid, first invalid, 0xFF
        push(8'h57); push(8'h07); push(8'h3C);
        expect_reply(8'h06, 1'b0);
        mregs[7] = 8'h3C;
        wait_idle("tb7", 30);
        push(8'h52); push(8'h08);
        expect_reply(8'h15, 1'b1);
        wait_idle("tb8", 30);
        push(8'h57); push(8'hFF); push(8'h01);
        expect_reply(8'h15, 1'b1);
        wait_idle("tbff", 30);
        check("tb_regs", reg_bus, pack_regs());

        // 4: timeout in GET_D
        push(8'h57); push(8'h02);
        expect_tmo();
        k = 0; seen = 0;
        while (seen < 2 && k < 50) begin
            @(negedge clk);
            if (bus.rd_uart) seen++;
            k++;
        end
        check("t4_pops_seen", seen, 2);
        cnt = 0;
        do begin
            @(negedge clk);
            cnt++;
        end while (!cmd_err && cnt < TIMEOUT + 10);
        check("t4_tmo_latency", cnt, TIMEOUT);
        check("t4_no_reply", bus.wr_uart, 0);
        @(negedge clk);
        check("t4_busy_after", busy, 0);
        tick(1);
        check("t4_regs", reg_bus, pack_regs());
        push(8'h52); push(8'h02);
        expect_reply(8'h00, 1'b0);
        wait_idle("t4", 30);

        // 5: Tx back-pressure with a second frame queued
        bus.Tx_full = 1'b1;
        push(8'h52); push(8'h03); push(8'h52); push(8'h03);
        expect_reply(8'hA5, 1'b0);
        expect_reply(8'hA5, 1'b0);
        tick(6);
        p0 = n_pops;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("t5_hold", {bus.wr_uart, bus.rd_uart}, 0);
        end
        check("t5_pops_held", n_pops - p0, 0);
        check("t5_rx_left", rx_q.size(), 2);
        check("t5_busy", busy, 1);
        tick(1);
        bus.Tx_full = 1'b0;
        @(negedge clk);
        check("t5_push_on_release", bus.wr_uart, 1);
        wait_idle("t5", 30);

        // 6: parity error during GET_D -> NAK, no write
        p0 = n_pops;
        push(8'h57); push(8'h01);
        k = 0;
        while (n_pops < p0 + 2 && k < 30) begin
            @(negedge clk);
            k++;
        end
        check("t6_pops", n_pops - p0, 2);
        tick(1);
        bus.parity_error = 1'b1;
        tick(1);
        bus.parity_error = 1'b0;
        push(8'hFF);
        expect_reply(8'h15, 1'b1);
        wait_idle("t6", 30);
        check("t6_regs", reg_bus, pack_regs());

        // reset mid-frame
        push(8'h57); push(8'h05);
        tick(5);
        check("t6_midframe_busy", busy, 1);
        rst_n = 1'b0;
        tick(1);
        @(negedge clk);
        check("t6_rst_outs", {bus.rd_uart, bus.wr_uart, bus.wr_data, busy, cmd_err}, 0);
        check("t6_rst_regs", reg_bus, 0);
        for (int i = 0; i < N_REGS; i++) mregs[i] = 8'h00;
        tick(1);
        rst_n = 1'b1;
        tick(5);
        check("t6_post_rst_busy", busy, 0);
        push(8'h52); push(8'h03);
        expect_reply(8'h00, 1'b0);
        wait_idle("t6_post", 30);

        tick(5);
        check("scoreboard_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
